// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: operand/start request and product/status bundle for the shift-add multiplier
interface shift_add_multiplier_if #(parameter int WIDTH = 5);
  logic               START;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               BUSY;
  logic               DONE;
  logic [2*WIDTH-1:0] P;
  modport master (output START, A, B, input BUSY, DONE, P);
  modport slave  (input START, A, B, output BUSY, DONE, P);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-add unsigned multiplier, one add/shift per cycle
// Optional macro ZERO_SKIP_EN: a zero operand completes straight away through FIN with P=0.
module shift_add_multiplier #(parameter int WIDTH = 5) (
  input logic CLK,
  input logic RST,
  shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, md_q, md_d;
  logic [CW-1:0] count_q, count_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0] sum;
  logic zero_op;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      md_q    <= '0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      md_q    <= md_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    md_d    = md_q;
    count_d = count_q;
    p_d     = p_q;
    // the carry out of the add lives only in sum[WIDTH]; it is shifted into ACC's MSB at once
    sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, md_q} : '0);
`ifdef ZERO_SKIP_EN
    zero_op = bus.A == '0 || bus.B == '0;
`else
    zero_op = 1'b0;
`endif
    if (state_q == IDLE && bus.START) begin
      md_d    = bus.A;
      mq_d    = bus.B;
      acc_d   = '0;
      count_d = '0;
      state_d = zero_op ? FIN : CALC;
      p_d     = zero_op ? '0 : p_q;
    end else if (state_q == CALC) begin
      acc_d   = sum[WIDTH:1];
      mq_d    = {sum[0], mq_q[WIDTH-1:1]};
      count_d = count_q + CW'(1);
      if (count_q == CW'(WIDTH - 1)) begin
        p_d     = {acc_d, mq_d};
        state_d = FIN;
      end
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
  end
  assign bus.BUSY = state_q == CALC;
  assign bus.DONE = state_q == FIN;
  assign bus.P    = p_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of the shift-add multiplier at WIDTH=5 and WIDTH=8
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  shift_add_multiplier_if #(.WIDTH(5)) bus();
  shift_add_multiplier_if #(.WIDTH(8)) bus8();
  shift_add_multiplier #(.WIDTH(5)) dut (.CLK(clk), .RST(rst), .bus(bus));
  shift_add_multiplier #(.WIDTH(8)) dut8 (.CLK(clk), .RST(rst), .bus(bus8));
  task automatic start_op(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask
  task automatic wait_done(output int cyc, output int busy);
    cyc = 0;
    busy = 0;
    while (bus.DONE !== 1'b1 && cyc < 30) begin
      if (bus.BUSY === 1'b1) busy++;
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    compared++; if (bus.BUSY !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    compared++; if (bus.DONE !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
    compared++; if (bus.P !== 10'd0) begin mismatched++; $display("FAIL reset_p: got %0d want 0", bus.P); end
    compared++; if (bus8.P !== 16'd0) begin mismatched++; $display("FAIL reset_p8: got %0d want 0", bus8.P); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    int cyc, busy;
    start_op(5'd5, 5'd3);
    wait_done(cyc, busy);
    compared++; if (cyc != 5) begin mismatched++; $display("FAIL basic_latency: got %0d want 5", cyc); end
    compared++; if (busy != 5) begin mismatched++; $display("FAIL basic_busy_cycles: got %0d want 5", busy); end
    compared++; if (bus.P !== 10'h00F) begin mismatched++; $display("FAIL basic_p: got %0d want 15", bus.P); end
    compared++; if (bus.BUSY !== 1'b0) begin mismatched++; $display("FAIL basic_busy_on_done: got %b want 0", bus.BUSY); end
    @(negedge clk);
    compared++; if (bus.DONE !== 1'b0) begin mismatched++; $display("FAIL basic_done_pulse: got %b want 0", bus.DONE); end
  endtask
  task automatic test_corners;
    logic [4:0] ta [3] = '{5'd31, 5'd1, 5'd31};
    logic [4:0] tb [3] = '{5'd31, 5'd31, 5'd1};
    logic [9:0] te [3] = '{10'd961, 10'd31, 10'd31};
    int cyc, busy;
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i]);
      wait_done(cyc, busy);
      compared++; if (bus.P !== te[i]) begin mismatched++; $display("FAIL corner_p[%0d]: got %0d want %0d", i, bus.P, te[i]); end
      @(negedge clk);
      compared++; if (bus.DONE !== 1'b0) begin mismatched++; $display("FAIL corner_done_once[%0d]: got %b want 0", i, bus.DONE); end
    end
  endtask
  task automatic test_back_to_back;
    logic [9:0] te [2] = '{10'd63, 10'd18};
    int cyc, busy;
    @(negedge clk);
    bus.A = 5'd7;
    bus.B = 5'd9;
    bus.START = 1'b1;
    wait_done(cyc, busy);
    compared++; if (bus.P !== 10'd63) begin mismatched++; $display("FAIL b2b_first_p: got %0d want 63", bus.P); end
    for (int i = 0; i < 2; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (cyc == 2) bus.A = 5'd2;
      end while (bus.DONE !== 1'b1 && cyc < 30);
      compared++; if (cyc != 7) begin mismatched++; $display("FAIL b2b_period[%0d]: got %0d want 7", i, cyc); end
      compared++; if (bus.P !== te[i]) begin mismatched++; $display("FAIL b2b_p[%0d]: got %0d want %0d", i, bus.P, te[i]); end
    end
    bus.START = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (bus.BUSY !== 1'b0) begin mismatched++; $display("FAIL b2b_stopped: got %b want 0", bus.BUSY); end
  endtask
  task automatic test_reset_abort;
    int cyc, busy;
    bit seen = 0;
    start_op(5'd12, 5'd10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++; if (bus.BUSY !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", bus.BUSY); end
    compared++; if (bus.P !== 10'd0) begin mismatched++; $display("FAIL abort_p: got %0d want 0", bus.P); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) seen = 1;
    end
    compared++; if (seen) begin mismatched++; $display("FAIL abort_no_done: got 1 want 0"); end
    start_op(5'd12, 5'd10);
    wait_done(cyc, busy);
    compared++; if (bus.P !== 10'd120) begin mismatched++; $display("FAIL abort_retry_p: got %0d want 120", bus.P); end
    @(negedge clk);
  endtask
  task automatic test_zero;
    int cyc, busy;
    start_op(5'd0, 5'd17);
    wait_done(cyc, busy);
`ifdef ZERO_SKIP_EN
    compared++; if (cyc != 0) begin mismatched++; $display("FAIL zero_latency: got %0d want 0", cyc); end
    compared++; if (busy != 0) begin mismatched++; $display("FAIL zero_busy: got %0d want 0", busy); end
`else
    compared++; if (cyc != 5) begin mismatched++; $display("FAIL zero_latency: got %0d want 5", cyc); end
    compared++; if (busy != 5) begin mismatched++; $display("FAIL zero_busy: got %0d want 5", busy); end
`endif
    compared++; if (bus.P !== 10'd0) begin mismatched++; $display("FAIL zero_p: got %0d want 0", bus.P); end
    @(negedge clk);
    compared++; if (bus.DONE !== 1'b0) begin mismatched++; $display("FAIL zero_done_once: got %b want 0", bus.DONE); end
  endtask
  task automatic test_width8;
    logic [7:0]  ta [2] = '{8'd255, 8'd128};
    logic [7:0]  tb [2] = '{8'd255, 8'd2};
    logic [15:0] te [2] = '{16'd65025, 16'd256};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus8.A = ta[i];
      bus8.B = tb[i];
      bus8.START = 1'b1;
      @(negedge clk);
      bus8.START = 1'b0;
      cyc = 0;
      while (bus8.DONE !== 1'b1 && cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
      compared++; if (cyc != 8) begin mismatched++; $display("FAIL w8_latency[%0d]: got %0d want 8", i, cyc); end
      compared++; if (bus8.P !== te[i]) begin mismatched++; $display("FAIL w8_p[%0d]: got %0d want %0d", i, bus8.P, te[i]); end
      @(negedge clk);
    end
  endtask
  initial begin
    bus.START = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus8.START = 1'b0;
    bus8.A = '0;
    bus8.B = '0;
    test_reset;
    test_basic;
    test_corners;
    test_back_to_back;
    test_reset_abort;
    test_zero;
    test_width8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
